hs_skid_buffer: RTL and testbench

Two-entry valid/ready skid buffer that sits directly upstream of the enable-gated D register stage; it converts a streaming handshake into a registered, back-pressure-tolerant data path. out_valid && out_ready forms the downstream register's enable, and out_data feeds its d input. The block fully registers the in_ready/out_ready path so pipeline stages can be chained without combinational ready loops, and sustains one transfer per cycle.

---
 rtl/hs_skid_buffer.sv | 115 +++++++++++
 tb/tb_hs_skid_buffer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/hs_skid_buffer.sv
// hs_skid_buffer: two-entry valid/ready skid buffer feeding an enable-gated
// D register stage. in_ready is decoded only from the state flops and flush,
// so chained stages never form a combinational ready loop. The buffer still
// sustains one transfer per cycle.
//
// Optional feature macro: HS_SKID_STALL_CNT_EN
//   When it is defined, stall_cnt is a saturating count of cycles where
//   out_valid && !out_ready. When it is undefined, stall_cnt is tied to 0
//   and no counter flops are built.
module hs_skid_buffer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             in_fire;
  logic             out_fire;

  // Handshake decode: ready depends only on state flops and flush, never on out_ready
  assign in_ready  = (state != FULL) && !flush;
  assign out_valid = (state != EMPTY);
  assign out_data  = main_q;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  // Occupancy follows directly from which entries the state says are live
  always_comb begin
    occupancy = 2'd0;
    case (state)
      EMPTY:   occupancy = 2'd0;
      ONE:     occupancy = 2'd1;
      FULL:    occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  // Entry state and data regs; flush overrides every transition, and data regs change only on capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            state  <= ONE;
            main_q <= in_data;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_q <= in_data;
          end else if (in_fire) begin
            state  <= FULL;
            skid_q <= in_data;
          end else if (out_fire) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            state  <= ONE;
            main_q <= skid_q;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

`ifdef HS_SKID_STALL_CNT_EN
  logic [CNT_W-1:0] stall_q;

  // Saturating count of back-pressured cycles, cleared by flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (flush) begin
      stall_q <= '0;
    end else if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
      stall_q <= stall_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_hs_skid_buffer.sv
// tb_hs_skid_buffer: directed self-checking bench for hs_skid_buffer.
// Expected stall_cnt values follow HS_SKID_STALL_CNT_EN (CNT_W = 4 here).
module tb_hs_skid_buffer;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             flush;
  logic [1:0]       occupancy;
  logic [CNT_W-1:0] stall_cnt;

  int compared;
  int mismatched;

  hs_skid_buffer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .flush     (flush),
    .occupancy (occupancy),
    .stall_cnt (stall_cnt)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] d,
                               input logic r, input logic f);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] expStall(input int k);
`ifdef HS_SKID_STALL_CNT_EN
    return (k > 15) ? 32'd15 : 32'(k);
`else
    return (k >= 0) ? 32'd0 : 32'd0;
`endif
  endfunction

  initial begin
    compared   = 0;
    mismatched = 0;
    rst_n      = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);

    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_data",  32'(out_data),  32'd0);
    checkOutput("rst_occupancy", 32'(occupancy), 32'd0);
    checkOutput("rst_in_ready",  32'(in_ready),  32'd1);
    checkOutput("rst_stall_cnt", 32'(stall_cnt), 32'd0);

    @(negedge clk);
    rst_n = 1'b1;

    // Streaming 0x01..0x10 with out_ready held high
    for (int i = 1; i <= 16; i++) begin
      applyStimulus(1'b1, 8'(i), 1'b1, 1'b0);
      tick();
      checkOutput("stream_data",  32'(out_data),  32'(i));
      checkOutput("stream_valid", 32'(out_valid), 32'd1);
      checkOutput("stream_occ",   32'(occupancy), 32'd1);
      checkOutput("stream_ready", 32'(in_ready),  32'd1);
    end
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    tick();
    checkOutput("stream_end_occ",   32'(occupancy), 32'd0);
    checkOutput("stream_end_valid", 32'(out_valid), 32'd0);

    // Back-pressure fill with 0xA1, 0xA2
    applyStimulus(1'b1, 8'hA1, 1'b0, 1'b0);
    tick();
    checkOutput("fill1_occ",  32'(occupancy), 32'd1);
    checkOutput("fill1_data", 32'(out_data),  32'hA1);
    applyStimulus(1'b1, 8'hA2, 1'b0, 1'b0);
    tick();
    checkOutput("fill2_occ",   32'(occupancy), 32'd2);
    checkOutput("fill2_ready", 32'(in_ready),  32'd0);
    checkOutput("fill2_data",  32'(out_data),  32'hA1);
    applyStimulus(1'b1, 8'hEE, 1'b0, 1'b0);
    tick();
    checkOutput("hold_data",  32'(out_data),  32'hA1);
    checkOutput("hold_valid", 32'(out_valid), 32'd1);
    checkOutput("hold_occ",   32'(occupancy), 32'd2);

    // Drain: 0xA1 leaves on the first edge, then 0xA2
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    tick();
    checkOutput("drain1_data",  32'(out_data),  32'hA2);
    checkOutput("drain1_occ",   32'(occupancy), 32'd1);
    checkOutput("drain1_ready", 32'(in_ready),  32'd1);
    tick();
    checkOutput("drain2_occ",   32'(occupancy), 32'd0);
    checkOutput("drain2_valid", 32'(out_valid), 32'd0);

    // Flush while FULL with 0xFF offered
    applyStimulus(1'b1, 8'hB1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 8'hB2, 1'b0, 1'b0);
    tick();
    checkOutput("pre_flush_occ", 32'(occupancy), 32'd2);
    applyStimulus(1'b1, 8'hFF, 1'b0, 1'b1);
    checkOutput("flush_in_ready", 32'(in_ready), 32'd0);
    tick();
    checkOutput("flush_occ",   32'(occupancy), 32'd0);
    checkOutput("flush_valid", 32'(out_valid), 32'd0);
    checkOutput("flush_data",  32'(out_data),  32'd0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    tick();
    checkOutput("post_flush_valid", 32'(out_valid), 32'd0);
    checkOutput("post_flush_data",  32'(out_data),  32'd0);
    checkOutput("post_flush_stall", 32'(stall_cnt), 32'd0);

    // Reset asserted between edges while FULL
    applyStimulus(1'b1, 8'hC1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 8'hC2, 1'b0, 1'b0);
    tick();
    checkOutput("pre_rst_occ", 32'(occupancy), 32'd2);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_data",  32'(out_data),  32'd0);
    checkOutput("midrst_occ",   32'(occupancy), 32'd0);
    checkOutput("midrst_ready", 32'(in_ready),  32'd1);
    checkOutput("midrst_stall", 32'(stall_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, 8'h5A, 1'b0, 1'b0);
    tick();
    checkOutput("post_rst_data", 32'(out_data),  32'h5A);
    checkOutput("post_rst_occ",  32'(occupancy), 32'd1);

    // Stall counting: hold out_valid=1 with out_ready=0 for 20 cycles
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    for (int k = 1; k <= 20; k++) begin
      tick();
      checkOutput("stall_cnt", 32'(stall_cnt), expStall(k));
    end
    checkOutput("stall_data", 32'(out_data), 32'h5A);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    tick();
    checkOutput("stall_flush_cnt", 32'(stall_cnt), 32'd0);
    checkOutput("stall_flush_occ", 32'(occupancy), 32'd0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    checkOutput("idle_stall_cnt", 32'(stall_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
